// File: rtl/clock_pkg.sv
// Shared types and default timing for the clock-setting front end.
// Timing defaults derive from the board clock so a new board only changes BOARD_CLK_HZ.
package clock_pkg;

  localparam int BOARD_CLK_HZ        = 100_000_000;
  localparam int DEBOUNCE_CYCLES_DEF = BOARD_CLK_HZ / 100;
  localparam int HOLD_CYCLES_DEF     = BOARD_CLK_HZ / 2;
  localparam int REPEAT_CYCLES_DEF   = BOARD_CLK_HZ / 10;
  localparam int CNT_W_DEF           = 26;

  typedef enum logic [2:0] {
    IDLE,
    HOLD_UP,
    HOLD_DN,
    REP_UP,
    REP_DN,
    LOCK
  } step_state_t;

endpackage

// File: rtl/updown_step_gen_btn_debounce.sv
// One push-button conditioner: 2-FF synchroniser, polarity fix, debounce.
// o_level is the debounced "pressed" flag; o_rise pulses in the cycle o_level goes high.
module btn_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_out;
  logic             btn_pressed;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= i_btn;
      sync_out  <= sync_meta;
    end
  end

  assign btn_pressed = (BTN_ACTIVE_LOW != 0) ? ~sync_out : sync_out;

  // Any cycle where the input agrees with the current level restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stable_cnt <= '0;
      o_level    <= 1'b0;
      o_rise     <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      if (btn_pressed != o_level) begin
        if (stable_cnt == CNT_LAST) begin
          stable_cnt <= '0;
          o_level    <= btn_pressed;
          o_rise     <= btn_pressed;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/updown_step_gen.sv
// Turns the two set buttons and the 1 Hz tick into ena/up/down strobes for the
// minutes/seconds counters, with press-and-hold auto-repeat; time freezes while setting.
module updown_step_gen
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_btn_up,
  input  logic i_btn_down,
  output logic o_ena,
  output logic o_up,
  output logic o_down,
  output logic o_busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             dup;
  logic             ddn;
  logic             pu;
  logic             pd;
  step_state_t      state;
  logic [CNT_W-1:0] timer;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_deb_up (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_up),
    .o_level (dup),
    .o_rise  (pu)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_deb_down (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_down),
    .o_level (ddn),
    .o_rise  (pd)
  );

  // Release/conflict exits are tested before timer expiry so they always suppress the step.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      timer  <= '0;
      o_ena  <= 1'b0;
      o_up   <= 1'b0;
      o_down <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      o_ena  <= 1'b0;
      o_up   <= 1'b0;
      o_down <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pu && !ddn) begin
            o_ena  <= 1'b1;
            o_up   <= 1'b1;
            timer  <= '0;
            state  <= HOLD_UP;
            o_busy <= 1'b1;
          end else if (pd && !dup) begin
            o_ena  <= 1'b1;
            o_down <= 1'b1;
            timer  <= '0;
            state  <= HOLD_DN;
            o_busy <= 1'b1;
          end else if (pu || pd) begin
            state  <= LOCK;
            o_busy <= 1'b1;
          end else if (i_tick) begin
            o_ena <= 1'b1;
            o_up  <= 1'b1;
          end
        end
        HOLD_UP, REP_UP: begin
          if (!dup) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (ddn) begin
            state <= LOCK;
          end else if (timer == ((state == HOLD_UP) ? HOLD_LAST : REPEAT_LAST)) begin
            o_ena <= 1'b1;
            o_up  <= 1'b1;
            timer <= '0;
            state <= REP_UP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HOLD_DN, REP_DN: begin
          if (!ddn) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (dup) begin
            state <= LOCK;
          end else if (timer == ((state == HOLD_DN) ? HOLD_LAST : REPEAT_LAST)) begin
            o_ena  <= 1'b1;
            o_down <= 1'b1;
            timer  <= '0;
            state  <= REP_DN;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        LOCK: begin
          if (!dup && !ddn) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_step_gen.sv
// Directed bench for updown_step_gen with short timing (debounce 4, hold 10, repeat 3).
// Every o_ena pulse is logged with its cycle number and compared with hand-derived schedules.
module tb_updown_step_gen;

  logic i_clk = 1'b0;
  logic i_reset;
  logic i_tick;
  logic i_btn_up;
  logic i_btn_down;
  logic o_ena;
  logic o_up;
  logic o_down;
  logic o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bad_outputs = 0;
  int k;

  int         step_cyc[$];
  logic [1:0] step_dir[$];
  int         exp_cyc[$];
  logic [1:0] exp_dir[$];

  localparam logic [1:0] DIR_UP = 2'b10;
  localparam logic [1:0] DIR_DN = 2'b01;

  updown_step_gen #(
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (10),
    .REPEAT_CYCLES   (3),
    .CNT_W           (26),
    .BTN_ACTIVE_LOW  (0)
  ) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_tick     (i_tick),
    .i_btn_up   (i_btn_up),
    .i_btn_down (i_btn_down),
    .o_ena      (o_ena),
    .o_up       (o_up),
    .o_down     (o_down),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Step log plus a running tally of illegal direction combinations.
  always @(negedge i_clk) begin
    if (o_ena === 1'b1) begin
      step_cyc.push_back(cyc);
      step_dir.push_back({o_up, o_down});
    end
    if ((o_ena !== 1'b1 && (o_up !== 1'b0 || o_down !== 1'b0)) ||
        (o_up === 1'b1 && o_down === 1'b1))
      bad_outputs++;
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_output(input string tag, input logic ena, input logic up,
                              input logic down, input logic busy);
    check_bit({tag, "_ena"},  o_ena,  ena);
    check_bit({tag, "_up"},   o_up,   up);
    check_bit({tag, "_down"}, o_down, down);
    check_bit({tag, "_busy"}, o_busy, busy);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge i_clk);
  endtask

  task automatic clear_steps();
    step_cyc.delete();
    step_dir.delete();
    exp_cyc.delete();
    exp_dir.delete();
  endtask

  task automatic expect_step(input int c, input logic [1:0] d);
    exp_cyc.push_back(c);
    exp_dir.push_back(d);
  endtask

  task automatic compare_steps(input string tag);
    int n;
    check_int({tag, "_count"}, step_cyc.size(), exp_cyc.size());
    n = (step_cyc.size() < exp_cyc.size()) ? step_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      check_int($sformatf("%s_cycle%0d", tag, i), step_cyc[i], exp_cyc[i]);
      check_int($sformatf("%s_dir%0d", tag, i), int'(step_dir[i]), int'(exp_dir[i]));
    end
  endtask

  initial begin
    // Reset held 3 cycles with both buttons pressed and the tick toggling.
    i_reset    = 1'b1;
    i_tick     = 1'b1;
    i_btn_up   = 1'b1;
    i_btn_down = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check_output($sformatf("reset%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
      i_tick = ~i_tick;
    end
    i_reset    = 1'b0;
    i_tick     = 1'b0;
    i_btn_up   = 1'b0;
    i_btn_down = 1'b0;
    @(negedge i_clk);
    check_output("after_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cycles(15);

    // Idle pass-through of a single tick.
    i_tick = 1'b1;
    @(negedge i_clk);
    i_tick = 1'b0;
    check_output("tick_pass", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge i_clk);
    check_output("tick_single", 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cycles(5);

    // 3-cycle glitch on up must be rejected.
    clear_steps();
    i_btn_up = 1'b1;
    wait_cycles(3);
    i_btn_up = 1'b0;
    wait_cycles(15);
    compare_steps("glitch");
    check_bit("glitch_busy", o_busy, 1'b0);

    // 5-cycle press: exactly one up step, 6 edges after the first sampled edge.
    clear_steps();
    k = cyc + 1;
    i_btn_up = 1'b1;
    wait_cycles(5);
    i_btn_up = 1'b0;
    wait_cycles(20);
    expect_step(k + 6, DIR_UP);
    compare_steps("pulse5");
    check_bit("pulse5_busy", o_busy, 1'b0);

    // Auto-repeat: hold 40 cycles, ticks at k+11 and k+26 must be dropped.
    clear_steps();
    k = cyc + 1;
    i_btn_up = 1'b1;
    for (int i = 0; i < 40; i++) begin
      i_tick = (i == 11 || i == 26);
      @(negedge i_clk);
    end
    i_tick   = 1'b0;
    i_btn_up = 1'b0;
    while (cyc < k + 45) @(negedge i_clk);
    check_bit("repeat_busy_held", o_busy, 1'b1);
    @(negedge i_clk);
    check_output("repeat_release", 1'b0, 1'b0, 1'b0, 1'b0);
    wait_cycles(10);
    expect_step(k + 6, DIR_UP);
    for (int m = 0; m < 10; m++) expect_step(k + 16 + 3 * m, DIR_UP);
    compare_steps("repeat");

    // Lock: down joins at the 5th held cycle; up released first, then down.
    clear_steps();
    k = cyc + 1;
    for (int i = 0; i < 30; i++) begin
      i_btn_up   = (i < 20);
      i_btn_down = (i >= 4 && i < 24);
      @(negedge i_clk);
    end
    check_bit("lock_busy_down_held", o_busy, 1'b1);
    @(negedge i_clk);
    check_bit("lock_busy_released", o_busy, 1'b0);
    wait_cycles(3);
    expect_step(k + 6, DIR_UP);
    compare_steps("lock");
    i_tick = 1'b1;
    @(negedge i_clk);
    i_tick = 1'b0;
    check_output("lock_then_tick", 1'b1, 1'b1, 1'b0, 1'b0);
    wait_cycles(5);

    // Reset during REP_DN, down still held afterwards.
    clear_steps();
    k = cyc + 1;
    i_btn_down = 1'b1;
    wait_cycles(20);
    i_reset = 1'b1;
    @(negedge i_clk);
    check_output("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
    i_reset = 1'b0;
    @(negedge i_clk);
    check_output("midreset_after", 1'b0, 1'b0, 1'b0, 1'b0);
    while (cyc < k + 28) @(negedge i_clk);
    i_btn_down = 1'b0;
    wait_cycles(15);
    expect_step(k + 6,  DIR_DN);
    expect_step(k + 16, DIR_DN);
    expect_step(k + 19, DIR_DN);
    expect_step(k + 27, DIR_DN);
    compare_steps("midreset_steps");
    check_bit("final_busy", o_busy, 1'b0);

    check_int("output_exclusive", bad_outputs, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
